// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory subsystem.
// Holds the main-memory arbiter FSM encoding and the round-robin wrap helper.
package segre_pkg;

  localparam int ADDR_SIZE        = 32;
  localparam int DCACHE_LANE_SIZE = 128;
  localparam int MM_ARB_N_CH      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } mm_arb_state_e;

  // Wraps a channel index that is at most one lap past the last channel.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/segre_mm_arbiter_rr.sv
// Combinational N-way round-robin pick: the first requester at or after ptr wins.
// Returns the winner both as one-hot and as an index, plus a valid flag.
module segre_rr_arbiter
  import segre_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c = IW'(rr_wrap(int'(ptr) + i, N));
      if (!valid && req[c]) begin
        valid  = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segre_mm_arbiter.sv
// Main-memory arbiter for N_CH cache channels: latches fill and writeback requests
// per channel and serialises them onto one memory port, writebacks first, round-robin.
module segre_mm_arbiter
  import segre_pkg::*;
#(
  parameter int N_CH   = MM_ARB_N_CH,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int LANE_W = DCACHE_LANE_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic [N_CH-1:0]          ch_rd_req_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_rd_addr_i,
  input  logic [N_CH-1:0]          ch_wb_req_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_wb_addr_i,
  input  logic [N_CH*LANE_W-1:0]   ch_wb_data_i,
  output logic [N_CH-1:0]          ch_rdy_o,
  output logic [LANE_W-1:0]        ch_data_o,
  output logic [ADDR_W-1:0]        ch_addr_o,
  output logic [N_CH-1:0]          ch_wb_done_o,
  output logic                     mm_rd_o,
  output logic [ADDR_W-1:0]        mm_addr_o,
  output logic                     mm_wr_o,
  output logic [ADDR_W-1:0]        mm_wr_addr_o,
  output logic [LANE_W-1:0]        mm_wr_data_o,
  input  logic                     mm_data_rdy_i,
  input  logic [LANE_W-1:0]        mm_rd_data_i,
  output logic                     proto_err_o,
  output logic [1:0]               state_o
);

  localparam int IW = $clog2(N_CH);

  // Handshake: channel requests are single-cycle pulses into a one-deep slot; memory
  // requests are levels held stable until mm_data_rdy_i, and completions come back
  // to the channel as single-cycle pulses one cycle after mm_data_rdy_i.
  logic [N_CH-1:0]   rd_v, wb_v;
  logic [ADDR_W-1:0] rd_addr [N_CH];
  logic [ADDR_W-1:0] wb_addr [N_CH];
  logic [LANE_W-1:0] wb_data [N_CH];

  mm_arb_state_e     state;
  logic [IW-1:0]     rr_ptr, gnt;
  logic [N_CH-1:0]   gnt_oh;

  logic [N_CH-1:0]   wb_oh, rd_oh, wb_clr, rd_clr;
  logic [IW-1:0]     wb_idx, rd_idx;
  logic              wb_any, rd_any;

  segre_rr_arbiter #(.N(N_CH)) u_wb_arb (
    .req(wb_v), .ptr(rr_ptr), .gnt(wb_oh), .idx(wb_idx), .valid(wb_any)
  );

  segre_rr_arbiter #(.N(N_CH)) u_rd_arb (
    .req(rd_v), .ptr(rr_ptr), .gnt(rd_oh), .idx(rd_idx), .valid(rd_any)
  );

  assign wb_clr  = (state == WRITE && mm_data_rdy_i) ? gnt_oh : '0;
  assign rd_clr  = (state == READ  && mm_data_rdy_i) ? gnt_oh : '0;
  assign state_o = state;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_v         <= '0;
      wb_v         <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rd_addr[i] <= '0;
        wb_addr[i] <= '0;
        wb_data[i] <= '0;
      end
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      gnt_oh       <= '0;
      ch_rdy_o     <= '0;
      ch_data_o    <= '0;
      ch_addr_o    <= '0;
      ch_wb_done_o <= '0;
      mm_rd_o      <= 1'b0;
      mm_addr_o    <= '0;
      mm_wr_o      <= 1'b0;
      mm_wr_addr_o <= '0;
      mm_wr_data_o <= '0;
      proto_err_o  <= 1'b0;
    end else begin
      ch_rdy_o     <= '0;
      ch_wb_done_o <= '0;

      // A pulse onto an occupied slot is dropped; the completing slot is still occupied.
      for (int i = 0; i < N_CH; i++) begin
        if ((ch_rd_req_i[i] && rd_v[i]) || (ch_wb_req_i[i] && wb_v[i]))
          proto_err_o <= 1'b1;
        if (rd_clr[i]) begin
          rd_v[i] <= 1'b0;
        end else if (ch_rd_req_i[i] && !rd_v[i]) begin
          rd_v[i]    <= 1'b1;
          rd_addr[i] <= ch_rd_addr_i[i*ADDR_W +: ADDR_W];
        end
        if (wb_clr[i]) begin
          wb_v[i] <= 1'b0;
        end else if (ch_wb_req_i[i] && !wb_v[i]) begin
          wb_v[i]    <= 1'b1;
          wb_addr[i] <= ch_wb_addr_i[i*ADDR_W +: ADDR_W];
          wb_data[i] <= ch_wb_data_i[i*LANE_W +: LANE_W];
        end
      end

      case (state)
        IDLE: begin
          if (wb_any) begin
            state        <= WRITE;
            gnt          <= wb_idx;
            gnt_oh       <= wb_oh;
            mm_wr_o      <= 1'b1;
            mm_wr_addr_o <= wb_addr[wb_idx];
            mm_wr_data_o <= wb_data[wb_idx];
          end else if (rd_any) begin
            state     <= READ;
            gnt       <= rd_idx;
            gnt_oh    <= rd_oh;
            mm_rd_o   <= 1'b1;
            mm_addr_o <= rd_addr[rd_idx];
          end
        end
        WRITE: begin
          if (mm_data_rdy_i) begin
            state        <= IDLE;
            mm_wr_o      <= 1'b0;
            ch_wb_done_o <= gnt_oh;
            rr_ptr       <= IW'(rr_wrap(int'(gnt) + 1, N_CH));
          end
        end
        READ: begin
          if (mm_data_rdy_i) begin
            state     <= IDLE;
            mm_rd_o   <= 1'b0;
            ch_rdy_o  <= gnt_oh;
            ch_data_o <= mm_rd_data_i;
            ch_addr_o <= mm_addr_o;
            rr_ptr    <= IW'(rr_wrap(int'(gnt) + 1, N_CH));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Scoreboard bench for segre_mm_arbiter with four channels and a behavioural memory.
// Directed scenarios push expected completions; a negedge monitor pops and compares.
module tb_segre_mm_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int LW = 32;
  localparam int EW = 1 + 2 + AW + LW;

  logic            clk_i, rsn_i;
  logic [N-1:0]    ch_rd_req_i, ch_wb_req_i;
  logic [N*AW-1:0] ch_rd_addr_i, ch_wb_addr_i;
  logic [N*LW-1:0] ch_wb_data_i;
  logic [N-1:0]    ch_rdy_o, ch_wb_done_o;
  logic [LW-1:0]   ch_data_o;
  logic [AW-1:0]   ch_addr_o;
  logic            mm_rd_o, mm_wr_o;
  logic [AW-1:0]   mm_addr_o, mm_wr_addr_o;
  logic [LW-1:0]   mm_wr_data_o;
  logic            mm_data_rdy_i;
  logic [LW-1:0]   mm_rd_data_i;
  logic            proto_err_o;
  logic [1:0]      state_o;

  segre_mm_arbiter #(.N_CH(N), .ADDR_W(AW), .LANE_W(LW)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ch_rd_req_i(ch_rd_req_i), .ch_rd_addr_i(ch_rd_addr_i),
    .ch_wb_req_i(ch_wb_req_i), .ch_wb_addr_i(ch_wb_addr_i), .ch_wb_data_i(ch_wb_data_i),
    .ch_rdy_o(ch_rdy_o), .ch_data_o(ch_data_o), .ch_addr_o(ch_addr_o),
    .ch_wb_done_o(ch_wb_done_o),
    .mm_rd_o(mm_rd_o), .mm_addr_o(mm_addr_o),
    .mm_wr_o(mm_wr_o), .mm_wr_addr_o(mm_wr_addr_o), .mm_wr_data_o(mm_wr_data_o),
    .mm_data_rdy_i(mm_data_rdy_i), .mm_rd_data_i(mm_rd_data_i),
    .proto_err_o(proto_err_o), .state_o(state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // scoreboard state: entry = {is_read, channel, address, data}
  logic [EW-1:0] exp_q[$];
  int            tests_run = 0;
  int            fails     = 0;
  int            mem_wait  = 0;
  logic [LW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] ra [N];
  logic [AW-1:0] wa [N];
  logic [LW-1:0] wd [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_rd(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_q.push_back({1'b1, 2'(ch), a, d});
  endtask

  task automatic push_wb(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_q.push_back({1'b0, 2'(ch), a, d});
  endtask

  // driver: one-cycle request pulses, called at posedge+1
  task automatic issue(input logic [N-1:0] rd, input logic [N-1:0] wb);
    for (int i = 0; i < N; i++) begin
      ch_rd_addr_i[i*AW +: AW] = ra[i];
      ch_wb_addr_i[i*AW +: AW] = wa[i];
      ch_wb_data_i[i*LW +: LW] = wd[i];
    end
    ch_rd_req_i = rd;
    ch_wb_req_i = wb;
    @(posedge clk_i); #1;
    ch_rd_req_i = '0;
    ch_wb_req_i = '0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // memory model: answers mem_wait cycles after a request level appears
  initial begin
    int cnt;
    cnt = 0;
    mm_data_rdy_i = 1'b0;
    mm_rd_data_i  = '0;
    forever begin
      @(posedge clk_i); #1;
      mm_data_rdy_i = 1'b0;
      if (!rsn_i || !(mm_rd_o || mm_wr_o)) begin
        cnt = 0;
      end else if (cnt >= mem_wait) begin
        cnt = 0;
        mm_data_rdy_i = 1'b1;
        if (mm_wr_o) mem[mm_wr_addr_o] = mm_wr_data_o;
        else mm_rd_data_i = mem.exists(mm_addr_o) ? mem[mm_addr_o] : {mm_addr_o, ~mm_addr_o};
      end else begin
        cnt++;
      end
    end
  end

  // monitor
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    logic [N-1:0]  oh;
    if (rsn_i && mm_rd_o && mm_wr_o) begin
      tests_run++;
      fails++;
      $display("FAIL both_mm_req actual=rd1_wr1 required=at_most_one");
    end
    if (rsn_i && (ch_rdy_o != '0 || ch_wb_done_o != '0)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_pulse actual=rdy:%b/wb_done:%b required=none", ch_rdy_o, ch_wb_done_o);
      end else begin
        e  = exp_q.pop_front();
        oh = N'(1) << e[LW+AW +: 2];
        if (e[EW-1]) begin
          check("fill_rdy",     ch_rdy_o,     oh);
          check("fill_wb_done", ch_wb_done_o, 0);
          check("fill_data",    ch_data_o,    e[LW-1:0]);
          check("fill_addr",    ch_addr_o,    e[LW +: AW]);
        end else begin
          check("wb_done",      ch_wb_done_o, oh);
          check("wb_rdy",       ch_rdy_o,     0);
        end
      end
    end
  end

  initial begin
    rsn_i        = 1'b0;
    ch_rd_req_i  = '0;
    ch_wb_req_i  = '0;
    ch_rd_addr_i = '0;
    ch_wb_addr_i = '0;
    ch_wb_data_i = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mm_rd",      mm_rd_o,      0);
    check("rst_mm_wr",      mm_wr_o,      0);
    check("rst_mm_addr",    mm_addr_o,    0);
    check("rst_mm_wr_addr", mm_wr_addr_o, 0);
    check("rst_mm_wr_data", mm_wr_data_o, 0);
    check("rst_ch_rdy",     ch_rdy_o,     0);
    check("rst_ch_wb_done", ch_wb_done_o, 0);
    check("rst_ch_data",    ch_data_o,    0);
    check("rst_ch_addr",    ch_addr_o,    0);
    check("rst_proto_err",  proto_err_o,  0);
    check("rst_state",      state_o,      0);
    rsn_i = 1'b1;
    @(posedge clk_i); #1;

    // fairness, pointer at 0: order 0,1,2,3
    mem_wait = 0;
    ra[0] = 16'h0010; ra[1] = 16'h0020; ra[2] = 16'h0030; ra[3] = 16'h0040;
    push_rd(0, 16'h0010, 32'h0010FFEF);
    push_rd(1, 16'h0020, 32'h0020FFDF);
    push_rd(2, 16'h0030, 32'h0030FFCF);
    push_rd(3, 16'h0040, 32'h0040FFBF);
    issue(4'b1111, 4'b0000);
    drain("burst_ptr0");

    // single read, memory ready 3 cycles after mm_rd_o; leaves pointer at 1
    mem_wait = 3;
    ra[0] = 16'h0100;
    push_rd(0, 16'h0100, 32'h0100FEFF);
    issue(4'b0001, 4'b0000);
    @(posedge clk_i); #1;
    check("rd_issue_latency", mm_rd_o,   1);
    check("rd_mm_addr",       mm_addr_o, 16'h0100);
    check("rd_no_wr",         mm_wr_o,   0);
    drain("single_read");

    // fairness, pointer at 1: order 1,2,3,0
    mem_wait = 0;
    ra[0] = 16'h0050; ra[1] = 16'h0060; ra[2] = 16'h0070; ra[3] = 16'h0080;
    push_rd(1, 16'h0060, 32'h0060FF9F);
    push_rd(2, 16'h0070, 32'h0070FF8F);
    push_rd(3, 16'h0080, 32'h0080FF7F);
    push_rd(0, 16'h0050, 32'h0050FFAF);
    issue(4'b1111, 4'b0000);
    drain("burst_ptr1");

    // eviction plus fill of the same lane: write first, fill sees the written data
    mem_wait = 2;
    wa[1] = 16'h0200; wd[1] = 32'hDEADBEEF; ra[1] = 16'h0200;
    push_wb(1, 16'h0200, 32'hDEADBEEF);
    push_rd(1, 16'h0200, 32'hDEADBEEF);
    issue(4'b0010, 4'b0010);
    @(posedge clk_i); #1;
    check("evict_wr_first", mm_wr_o,      1);
    check("evict_wr_addr",  mm_wr_addr_o, 16'h0200);
    check("evict_wr_data",  mm_wr_data_o, 32'hDEADBEEF);
    drain("evict_fill");

    // writeback arriving during a read beats the other pending read
    mem_wait = 4;
    ra[0] = 16'h0500;
    push_rd(0, 16'h0500, 32'h0500FAFF);
    issue(4'b0001, 4'b0000);
    @(posedge clk_i); #1;
    check("prio_read_granted", mm_rd_o, 1);
    wa[2] = 16'h0600; wd[2] = 32'h12345678; ra[1] = 16'h0700;
    push_wb(2, 16'h0600, 32'h12345678);
    push_rd(1, 16'h0700, 32'h0700F8FF);
    issue(4'b0010, 4'b0100);
    drain("priority");

    // second pulse on a pending read slot
    check("proto_err_clear", proto_err_o, 0);
    mem_wait = 4;
    ra[0] = 16'h0300;
    push_rd(0, 16'h0300, 32'h0300FCFF);
    issue(4'b0001, 4'b0000);
    ra[0] = 16'h0340;
    issue(4'b0001, 4'b0000);
    check("proto_err_set", proto_err_o, 1);
    drain("proto_err");
    repeat (5) @(posedge clk_i);
    #1;
    check("proto_err_sticky", proto_err_o, 1);
    check("proto_no_refetch", mm_rd_o,     0);

    // reset in the middle of a write
    mem_wait = 20;
    wa[3] = 16'h0400; wd[3] = 32'hCAFEF00D;
    issue(4'b0000, 4'b1000);
    @(posedge clk_i); #1;
    check("wr_before_reset", mm_wr_o, 1);
    #2 rsn_i = 1'b0;
    #1;
    check("reset_drops_wr",      mm_wr_o,      0);
    check("reset_wr_addr",       mm_wr_addr_o, 0);
    check("reset_clears_proto",  proto_err_o,  0);
    @(posedge clk_i); #1;
    rsn_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("post_reset_wr",    mm_wr_o,      0);
    check("post_reset_rd",    mm_rd_o,      0);
    check("post_reset_state", state_o,      0);
    check("post_reset_done",  ch_wb_done_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
